// File: rtl/sync_frame_tx_pkg.sv
// sync_frame_tx_pkg: constants and types shared by both ends of the sync-marker link.
// Holds the 5-bit marker, its length, the 2-bit state encoding and small helpers.
// No ports; imported by the transmitter and the receiver-side detector.
package sync_frame_tx_pkg;

  localparam logic [4:0] SYNC_PATTERN = 5'b10010;
  localparam int         SYNC_LEN     = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Marker bit sent at position idx (0 = first on the line, i.e. pattern bit 4).
  function automatic logic sync_bit(input int idx);
    logic [SYNC_LEN-1:0] p;
    p = SYNC_PATTERN << idx;
    return p[SYNC_LEN-1];
  endfunction

endpackage

// File: rtl/sync_frame_tx_if.sv
// sync_frame_tx_if: payload handshake into the frame transmitter.
// Ports: in_data (DATA_W), in_valid from the producer; in_ready back from the transmitter.
// master = payload producer, slave = transmitter.
interface sync_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/sync_frame_tx_bit_tick_gen.sv
// bit_tick_gen: paces serial bits; tick is high in the last clock of every bit period.
// Ports: clk, rst (async active-low), restart (zero the count, start a new bit), tick.
// The count wraps after CLKS_PER_BIT clocks; with CLKS_PER_BIT=1 tick is always high.
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sync_frame_tx.sv
// sync_frame_tx: serial frame transmitter - marker 1,0,0,1,0, payload MSB-first, GAP_LEN zeros.
// Ports: clk, rst (async active-low), in_if (payload valid/ready, ready only in IDLE),
//        tx_bit / tx_active (registered line and busy flag), frame_done (last clock of frame).
module sync_frame_tx
  import sync_frame_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_LEN      = 2
) (
  input  logic             clk,
  input  logic             rst,
  sync_frame_tx_if.slave   in_if,
  output logic             tx_bit,
  output logic             tx_active,
  output logic             frame_done
);

  localparam int MAX_BITS = max3(SYNC_LEN, DATA_W, GAP_LEN);
  localparam int IDX_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  bit_idx, idx_nxt;
  logic [DATA_W-1:0] shreg, sh_nxt;
  logic              bit_nxt, active_nxt;
  logic              accept, tick;
  logic              last_sync, last_data, last_gap;

  assign in_if.in_ready = (state == ST_IDLE);
  assign accept         = in_if.in_valid && in_if.in_ready;

  // Restarting on accept aligns the first marker bit to a full bit period.
  bit_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (accept),
    .tick    (tick)
  );

  assign last_sync = (int'(bit_idx) == SYNC_LEN - 1);
  assign last_data = (int'(bit_idx) == DATA_W - 1);
  assign last_gap  = (GAP_LEN > 0) && (int'(bit_idx) == GAP_LEN - 1);

  // tx_bit is registered, so the combinational block computes the value the
  // line will carry in the next clock; state/bit_idx describe the current bit.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = bit_idx;
    sh_nxt     = shreg;
    bit_nxt    = tx_bit;
    frame_done = 1'b0;
    unique case (state)
      ST_IDLE: begin
        bit_nxt = 1'b0;
        if (accept) begin
          state_nxt = ST_SYNC;
          idx_nxt   = '0;
          sh_nxt    = in_if.in_data;
          bit_nxt   = sync_bit(0);
        end
      end
      ST_SYNC: begin
        if (tick) begin
          if (last_sync) begin
            state_nxt = ST_DATA;
            idx_nxt   = '0;
            bit_nxt   = shreg[DATA_W-1];
            sh_nxt    = shreg << 1;
          end else begin
            idx_nxt = bit_idx + IDX_W'(1);
            bit_nxt = sync_bit(int'(bit_idx) + 1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (last_data) begin
            idx_nxt    = '0;
            bit_nxt    = 1'b0;
            frame_done = (GAP_LEN == 0);
            state_nxt  = (GAP_LEN > 0) ? ST_GAP : ST_IDLE;
          end else begin
            idx_nxt = bit_idx + IDX_W'(1);
            bit_nxt = shreg[DATA_W-1];
            sh_nxt  = shreg << 1;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          bit_nxt = 1'b0;
          if (last_gap) begin
            frame_done = 1'b1;
            state_nxt  = ST_IDLE;
            idx_nxt    = '0;
          end else begin
            idx_nxt = bit_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
        bit_nxt   = 1'b0;
      end
    endcase
    active_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      bit_idx   <= '0;
      shreg     <= '0;
      tx_bit    <= 1'b0;
      tx_active <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_idx   <= idx_nxt;
      shreg     <= sh_nxt;
      tx_bit    <= bit_nxt;
      tx_active <= active_nxt;
    end
  end

endmodule

// File: tb/tb_sync_frame_tx.sv
// tb_sync_frame_tx: three transmitter configurations (8/1/2, 8/3/2, 1/1/0) checked
// cycle by cycle against a line model built from marker, payload and gap bits.
// No ports; prints one summary line at the end.
module tb_sync_frame_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_frame_tx_if #(.DATA_W(8)) if_a ();
  sync_frame_tx_if #(.DATA_W(8)) if_b ();
  sync_frame_tx_if #(.DATA_W(1)) if_c ();

  logic a_bit, a_act, a_done;
  logic b_bit, b_act, b_done;
  logic c_bit, c_act, c_done;

  sync_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .GAP_LEN(2)) dut_a (
    .clk(clk), .rst(rst), .in_if(if_a), .tx_bit(a_bit), .tx_active(a_act), .frame_done(a_done));
  sync_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(3), .GAP_LEN(2)) dut_b (
    .clk(clk), .rst(rst), .in_if(if_b), .tx_bit(b_bit), .tx_active(b_act), .frame_done(b_done));
  sync_frame_tx #(.DATA_W(1), .CLKS_PER_BIT(1), .GAP_LEN(0)) dut_c (
    .clk(clk), .rst(rst), .in_if(if_c), .tx_bit(c_bit), .tx_active(c_act), .frame_done(c_done));

  int errors = 0;
  int checks = 0;
  int dw[3] = '{8, 8, 1};
  int ck[3] = '{1, 3, 1};
  int gp[3] = '{2, 2, 0};

  logic exp_q[$];
  logic obs_q[$];
  int   active_cnt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic v, input logic [7:0] d);
    case (w)
      0: begin if_a.in_valid = v; if_a.in_data = d; end
      1: begin if_b.in_valid = v; if_b.in_data = d; end
      2: begin if_c.in_valid = v; if_c.in_data = d[0:0]; end
      default: ;
    endcase
  endtask

  task automatic sample(input int w, output logic b, output logic act, output logic done,
                        output logic rdy);
    case (w)
      0: begin b = a_bit; act = a_act; done = a_done; rdy = if_a.in_ready; end
      1: begin b = b_bit; act = b_act; done = b_done; rdy = if_b.in_ready; end
      default: begin b = c_bit; act = c_act; done = c_done; rdy = if_c.in_ready; end
    endcase
  endtask

  // Expected line: marker, payload MSB-first, gap zeros, each bit held ck[w] clocks.
  task automatic build_exp(input int w, input logic [7:0] d);
    logic [4:0] mk;
    logic [4:0] ms;
    logic [7:0] ds;
    mk = 5'b10010;
    exp_q.delete();
    for (int i = 4; i >= 0; i--) begin
      ms = mk >> i;
      repeat (ck[w]) exp_q.push_back(ms[0]);
    end
    for (int i = dw[w] - 1; i >= 0; i--) begin
      ds = d >> i;
      repeat (ck[w]) exp_q.push_back(ds[0]);
    end
    repeat (gp[w] * ck[w]) exp_q.push_back(1'b0);
  endtask

  task automatic check_idle(input int w, input string tag);
    logic b, act, done, rdy;
    sample(w, b, act, done, rdy);
    checks++;
    if ({b, act, done, rdy} !== 4'b0001) begin
      errors++;
      $display("FAIL %s idle w=%0d got bit/act/done/rdy=%b%b%b%b exp=0001", tag, w, b, act, done, rdy);
    end
  endtask

  // Called in an idle cycle; accepts d at the next edge and checks every frame cycle.
  // hold keeps in_valid high with junk data while busy; keep leaves it high at the end.
  task automatic run_frame(input int w, input logic [7:0] d, input bit hold, input bit keep);
    logic b, act, done, rdy;
    int n;
    build_exp(w, d);
    n = exp_q.size();
    obs_q.delete();
    active_cnt = 0;
    sample(w, b, act, done, rdy);
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_accept w=%0d got=%b exp=1", w, rdy);
    end
    drive(w, 1'b1, d);
    step();
    for (int k = 0; k < n; k++) begin
      drive(w, hold && (keep || k < n - 1), 8'($urandom));
      sample(w, b, act, done, rdy);
      obs_q.push_back(b);
      if (act) active_cnt++;
      checks++;
      if (b !== exp_q[k]) begin
        errors++;
        $display("FAIL line w=%0d d=%h cyc=%0d got=%b exp=%b", w, d, k + 1, b, exp_q[k]);
      end
      checks++;
      if (act !== 1'b1) begin
        errors++;
        $display("FAIL active w=%0d cyc=%0d got=%b exp=1", w, k + 1, act);
      end
      checks++;
      if (done !== (k == n - 1)) begin
        errors++;
        $display("FAIL frame_done w=%0d cyc=%0d got=%b exp=%b", w, k + 1, done, (k == n - 1));
      end
      checks++;
      if (rdy !== 1'b0) begin
        errors++;
        $display("FAIL ready_busy w=%0d cyc=%0d got=%b exp=0", w, k + 1, rdy);
      end
      step();
    end
    check_idle(w, "after_frame");
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 8'h00);
    #3;
    for (int w = 0; w < 3; w++) check_idle(w, "reset");
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [14:0] spec_line;
    spec_line = 15'b100101010010100;
    run_frame(0, 8'hA5, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) begin
      checks++;
      if (obs_q[k] !== spec_line[14 - k]) begin
        errors++;
        $display("FAIL basic_a5 cyc=%0d got=%b exp=%b", k + 1, obs_q[k], spec_line[14 - k]);
      end
    end
  endtask

  // Receiver-side Mealy detector on the looped-back line: fires in the clock that
  // completes 1,0,0,1,0. A5 itself holds that run across cycles 8..12, so the
  // expected hit list is taken from the model line rather than assumed.
  task automatic test_loopback();
    logic [4:0] wo, we;
    int det_o[$];
    int det_e[$];
    run_frame(0, 8'hA5, 1'b0, 1'b0);
    wo = '0;
    we = '0;
    for (int k = 0; k < obs_q.size(); k++) begin
      wo = {wo[3:0], obs_q[k]};
      we = {we[3:0], exp_q[k]};
      if (wo == 5'b10010) det_o.push_back(k + 1);
      if (we == 5'b10010) det_e.push_back(k + 1);
    end
    checks++;
    if (det_o.size() == 0 || det_o[0] != 5) begin
      errors++;
      $display("FAIL loopback_first_detect got=%0d exp=5", (det_o.size() == 0) ? -1 : det_o[0]);
    end
    checks++;
    if (det_o.size() != det_e.size()) begin
      errors++;
      $display("FAIL loopback_detect_count got=%0d exp=%0d", det_o.size(), det_e.size());
    end else begin
      for (int i = 0; i < det_o.size(); i++) begin
        checks++;
        if (det_o[i] != det_e[i]) begin
          errors++;
          $display("FAIL loopback_detect_pos got=%0d exp=%0d", det_o[i], det_e[i]);
        end
      end
    end
  endtask

  task automatic test_slow_bits();
    run_frame(1, 8'h01, 1'b0, 1'b0);
    checks++;
    if (active_cnt != 45) begin
      errors++;
      $display("FAIL slow_active_span got=%0d exp=45", active_cnt);
    end
  endtask

  task automatic test_back_to_back();
    run_frame(0, 8'hFF, 1'b1, 1'b1);
    run_frame(0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    logic b, act, done, rdy;
    build_exp(0, 8'h1F);
    drive(0, 1'b1, 8'h1F);
    step();
    drive(0, 1'b0, 8'h00);
    repeat (8) step();
    sample(0, b, act, done, rdy);
    checks++;
    if ({b, act} !== {exp_q[8], 1'b1}) begin
      errors++;
      $display("FAIL pre_reset_data_bit3 got bit/act=%b%b exp=%b1", b, act, exp_q[8]);
    end
    #2;
    rst = 1'b0;
    #1;
    check_idle(0, "async_reset");
    step();
    rst = 1'b1;
    run_frame(0, 8'h5A, 1'b0, 1'b0);
  endtask

  task automatic test_single_bit_no_gap();
    run_frame(2, 8'h01, 1'b0, 1'b0);
    run_frame(2, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int w;
    for (int it = 0; it < 24; it++) begin
      w = $urandom_range(0, 2);
      run_frame(w, 8'($urandom), bit'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 3)) begin
        step();
        check_idle(w, "random_gap");
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_loopback();
    test_slow_bits();
    test_back_to_back();
    test_reset_mid_frame();
    test_single_bit_no_gap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
